// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between fetch and imem.
// Requests are valid/ready; responses return in request order.
interface fetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// RV64 fetch stage: owns the PC, issues in-order imem requests, buffers
// returned words and presents one instruction per cycle to decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [63:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic [31:0]         inst,
  output logic [63:0]         inst_pc,
  output logic                inst_valid
);

  localparam int          CW    = 4;
  localparam logic [CW:0] DEPTH = (CW+1)'(BUF_DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [63:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d;
  logic [7:0]    drop_q, drop_d;
  logic [31:0]   buf_inst_q [BUF_DEPTH];
  logic [31:0]   buf_inst_d [BUF_DEPTH];
  logic [63:0]   buf_pc_q   [BUF_DEPTH];
  logic [63:0]   buf_pc_d   [BUF_DEPTH];
  logic [63:0]   rsp_pc_q   [BUF_DEPTH];
  logic [63:0]   rsp_pc_d   [BUF_DEPTH];

  logic          accept, pop, resp_live, resp_drop;
  logic [CW-1:0] buf_widx, rsp_widx;

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? buf_inst_q[0] : NOP;
  assign inst_pc    = inst_valid ? buf_pc_q[0]   : 64'h0;

  assign pop       = inst_valid && !stall && !redirect;
  assign resp_live = imem.resp_valid && (drop_q == '0);
  assign resp_drop = imem.resp_valid && (drop_q != '0);

  // A slot freed by this cycle's dequeue is reusable immediately, which is
  // what sustains one instruction per cycle with a 2-entry buffer.
  assign imem.req_valid = reset && !redirect &&
                          (({1'b0, count_q} + {1'b0, inflight_q}
                            - {{CW{1'b0}}, pop}) < DEPTH);
  assign imem.req_addr  = pc_q;
  assign accept         = imem.req_valid && imem.req_ready;

  assign buf_widx = count_q    - {{(CW-1){1'b0}}, pop};
  assign rsp_widx = inflight_q - {{(CW-1){1'b0}}, resp_live};

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    rsp_pc_d   = rsp_pc_q;
    if (redirect) begin
      pc_d       = {redirect_pc[63:2], 2'b00};
      count_d    = '0;
      inflight_d = '0;
      // Everything still in flight becomes stale; whatever arrives now
      // (live or already-dropped) is retired this cycle.
      drop_d     = drop_q + {4'b0, inflight_q} - {7'b0, imem.resp_valid};
    end else begin
      if (accept)    pc_d   = pc_q + 64'd4;
      if (resp_drop) drop_d = drop_q - 8'd1;
      if (pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) begin
          buf_inst_d[i] = buf_inst_q[i+1];
          buf_pc_d[i]   = buf_pc_q[i+1];
        end
      end
      if (resp_live) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) rsp_pc_d[i] = rsp_pc_q[i+1];
      end
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (resp_live && buf_widx == CW'(i)) begin
          buf_inst_d[i] = imem.resp_data;
          buf_pc_d[i]   = rsp_pc_q[0];
        end
        if (accept && rsp_widx == CW'(i)) rsp_pc_d[i] = pc_q;
      end
      count_d    = count_q + {{(CW-1){1'b0}}, resp_live} - {{(CW-1){1'b0}}, pop};
      inflight_d = inflight_q + {{(CW-1){1'b0}}, accept}
                   - {{(CW-1){1'b0}}, resp_live};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      buf_inst_q <= '{default: '0};
      buf_pc_q   <= '{default: '0};
      rsp_pc_q   <= '{default: '0};
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
      rsp_pc_q   <= rsp_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with variable latency plus a
// scoreboard of expected {pc, word} pairs checked as decode consumes them.
module tb_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;

  fetch_unit_if imem();

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(imem),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [63:0] addr; } mreq_t;
  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] next_pc;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
  endfunction

  // Memory model and scoreboard: sample at negedge, drive responses after posedge.
  initial begin
    logic [63:0] e;
    imem.resp_valid = 1'b0;
    imem.resp_data  = 32'h0;
    next_pc = RST_PC;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        mem_q.delete();
        next_pc = RST_PC;
      end else begin
        if (imem.req_valid) begin
          checks++;
          if (imem.req_addr !== next_pc) begin
            failures++;
            $display("FAIL req_addr: got %h expected %h", imem.req_addr, next_pc);
          end
        end
        if (inst_valid && !stall && !redirect) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_extra: got inst_pc %h expected no instruction", inst_pc);
          end else begin
            e = exp_q.pop_front();
            if (inst_pc !== e || inst !== word_of(e)) begin
              failures++;
              $display("FAIL sb_inst: got %h/%h expected %h/%h",
                       inst_pc, inst, e, word_of(e));
            end
          end
        end
        if (redirect) begin
          exp_q.delete();
          next_pc = {redirect_pc[63:2], 2'b00};
        end
        if (imem.req_valid && imem.req_ready) begin
          mem_q.push_back('{due: cyc + lat, addr: imem.req_addr});
          exp_q.push_back(imem.req_addr);
          next_pc = next_pc + 64'd4;
        end
        if (imem.resp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem.resp_valid = 1'b1;
        imem.resp_data  = word_of(mem_q[0].addr);
      end else begin
        imem.resp_valid = 1'b0;
        imem.resp_data  = 32'h0;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (imem.req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 64'h0) begin
      failures++;
      $display("FAIL reset_outputs: got rv=%b iv=%b inst=%h pc=%h expected 0/0/%h/0",
               imem.req_valid, inst_valid, inst, inst_pc, NOP);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (imem.req_valid !== 1'b1 || imem.req_addr !== RST_PC) begin
      failures++;
      $display("FAIL reset_release: got rv=%b addr=%h expected 1/%h",
               imem.req_valid, imem.req_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    logic        ev;
    logic [63:0] ep;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ev = (k >= 2);
      ep = (k >= 2) ? RST_PC + 64'(4 * (k - 2)) : 64'h0;
      checks++;
      if (inst_valid !== ev || inst_pc !== ep) begin
        failures++;
        $display("FAIL stream_k%0d: got v=%b pc=%h expected v=%b pc=%h",
                 k, inst_valid, inst_pc, ev, ep);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] held;
    @(posedge clk);
    #2 stall = 1'b1;
    held = (exp_q.size() > 0) ? exp_q[0] : 64'hX;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== held || inst !== word_of(held)
          || imem.req_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_k%0d: got v=%b pc=%h inst=%h rv=%b expected 1/%h/%h/0",
                 k, inst_valid, inst_pc, inst, imem.req_valid, held, word_of(held));
      end
    end
    @(posedge clk);
    #2 stall = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_ready_low();
    logic [63:0] held;
    #2 imem.req_ready = 1'b0;
    held = next_pc;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (imem.req_addr !== held) begin
        failures++;
        $display("FAIL ready_low_addr_k%0d: got %h expected %h", k, imem.req_addr, held);
      end
    end
    checks++;
    if (inst_valid !== 1'b0 || imem.req_valid !== 1'b1) begin
      failures++;
      $display("FAIL ready_low_drain: got iv=%b rv=%b expected 0/1", inst_valid, imem.req_valid);
    end
    @(posedge clk);
    #2 imem.req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (imem.req_valid !== 1'b1 || imem.req_addr !== held) begin
      failures++;
      $display("FAIL ready_resume: got rv=%b addr=%h expected 1/%h",
               imem.req_valid, imem.req_addr, held);
    end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    #2 lat = 3;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #2;
      if (mem_q.size() == 2 && !imem.resp_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL redirect_setup: got no cycle with 2 in flight expected one within 20");
    end
    redirect = 1'b1;
    redirect_pc = 64'h2002;
    @(negedge clk);
    checks++;
    if (imem.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_withdraw: got rv=%b expected 0", imem.req_valid);
    end
    @(posedge clk);
    #2 redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || imem.req_valid !== 1'b1 || imem.req_addr !== 64'h2000) begin
      failures++;
      $display("FAIL redirect_next: got iv=%b rv=%b addr=%h expected 0/1/2000",
               inst_valid, imem.req_valid, imem.req_addr);
    end
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (inst_valid) found = 1'b1;
    end
    checks++;
    if (!found || inst_pc !== 64'h2000) begin
      failures++;
      $display("FAIL redirect_first: got found=%b pc=%h expected 1/2000", found, inst_pc);
    end
    @(posedge clk);
    #2 lat = 1;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_redirect_resp_stall();
    bit found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk);
      #2;
      if (imem.resp_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rrs_setup: got no response cycle expected one within 10");
    end
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h3000;
    @(posedge clk);
    #2;
    redirect = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || imem.req_valid !== 1'b1 || imem.req_addr !== 64'h3000) begin
      failures++;
      $display("FAIL rrs_next: got iv=%b rv=%b addr=%h expected 0/1/3000",
               inst_valid, imem.req_valid, imem.req_addr);
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (inst_valid) found = 1'b1;
    end
    checks++;
    if (!found || inst_pc !== 64'h3000 || inst !== word_of(64'h3000)) begin
      failures++;
      $display("FAIL rrs_first: got found=%b pc=%h inst=%h expected 1/3000/%h",
               found, inst_pc, inst, word_of(64'h3000));
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (imem.req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 64'h0) begin
      failures++;
      $display("FAIL async_reset: got rv=%b iv=%b inst=%h pc=%h expected 0/0/%h/0",
               imem.req_valid, inst_valid, inst, inst_pc, NOP);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (imem.req_valid !== 1'b1 || imem.req_addr !== RST_PC) begin
      failures++;
      $display("FAIL async_release: got rv=%b addr=%h expected 1/%h",
               imem.req_valid, imem.req_addr, RST_PC);
    end
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (inst_valid) found = 1'b1;
    end
    checks++;
    if (!found || inst_pc !== RST_PC) begin
      failures++;
      $display("FAIL async_restart: got found=%b pc=%h expected 1/%h", found, inst_pc, RST_PC);
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    imem.req_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_ready_low();
    test_redirect();
    test_redirect_resp_stall();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
